// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS load/store unit: access sizes, FSM states, bus timeout default.
// Pure declarations; no latency or flow control of its own.
package mips_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores, lane select plus sign/zero extension for loads, alignment check.
// Purely combinational (0 cycles); no flow control.
module lsu_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_off,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_ld_raw,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sx;

    always_comb begin
        o_be       = 4'b1111;
        o_wdata    = i_st_data;
        o_misalign = 1'b0;
        case (i_st_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_st_off;
                o_wdata = {4{i_st_data[7:0]}};
            end
            SZ_HALF: begin
                o_be       = i_st_off[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_st_data[15:0]}};
                o_misalign = i_st_off[0];
            end
            // size 11 is handled exactly like a word
            default: o_misalign = (i_st_off != 2'b00);
        endcase
    end

    assign w_byte = i_ld_raw[{i_ld_off, 3'b000} +: 8];
    assign w_half = i_ld_off[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];
    assign w_sx   = ~i_ld_unsigned;

    always_comb begin
        o_ld_data = i_ld_raw;
        case (i_ld_size)
            SZ_BYTE: o_ld_data = {{24{w_sx & w_byte[7]}}, w_byte};
            SZ_HALF: o_ld_data = {{16{w_sx & w_half[15]}}, w_half};
            default: o_ld_data = i_ld_raw;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// MIPS datapath load/store unit: IDLE/REQ/DONE bus handshake, min 3 cycles per access.
// Stalls the datapath from request until DONE; waits for bus_ack up to TIMEOUT cycles.
module mips_lsu
    import mips_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wrt,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        stall,
    output logic        align_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;

    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic        r_bus_err;
    logic [31:0] r_rd_data;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_uns;
    logic [31:0] r_cnt;

    logic [31:0] w_cnt_nxt;
    logic        w_start;
    logic        w_ack;
    logic        w_timeout;
    logic        w_align;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_data;

    lsu_lane_align u_lane (
        .i_st_size     (size),
        .i_st_off      (addr[1:0]),
        .i_st_data     (wr_data),
        .i_ld_size     (r_size),
        .i_ld_off      (r_off),
        .i_ld_unsigned (r_uns),
        .i_ld_raw      (bus_rdata),
        .o_be          (w_be),
        .o_wdata       (w_wdata),
        .o_ld_data     (w_ld_data),
        .o_misalign    (w_misalign)
    );

    assign w_cnt_nxt = r_cnt + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // reset gates the IDLE decode so stall/align_err stay low while reset is held
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        w_align     = 1'b0;
        stall       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((mem_rd || mem_wrt) && reset) begin
                    if (w_misalign) begin
                        w_align = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        stall       = 1'b1;
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (bus_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if ((TIMEOUT != 0) && (w_cnt_nxt == 32'(TIMEOUT))) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_bus_err   <= 1'b0;
            r_rd_data   <= '0;
            r_size      <= SZ_WORD;
            r_off       <= '0;
            r_uns       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_bus_err <= w_timeout;
            if (w_start) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= mem_wrt;
                r_bus_addr  <= {addr[31:2], 2'b00};
                r_bus_be    <= w_be;
                r_bus_wdata <= w_wdata;
                r_size      <= size;
                r_off       <= addr[1:0];
                r_uns       <= ld_unsigned;
                r_cnt       <= '0;
            end else if (r_state == ST_REQ) begin
                r_cnt <= w_cnt_nxt;
            end
            if (w_ack || w_timeout) r_bus_req <= 1'b0;
            if (w_ack && !r_bus_we) r_rd_data <= w_ld_data;
            if (w_timeout || w_align) r_rd_data <= '0;
        end
    end

    assign rd_data   = w_align ? 32'd0 : r_rd_data;
    assign align_err = w_align;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed self-checking bench for mips_lsu (TIMEOUT=4): stores, loads, misalignment,
// timeout, reset during a request and back-to-back accesses.
module tb_mips_lsu;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd, mem_wrt, ld_unsigned;
    logic [1:0]  size;
    logic [31:0] addr, wr_data, rd_data;
    logic        stall, align_err, bus_req, bus_we, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_lsu #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_rd      (mem_rd),
        .mem_wrt     (mem_wrt),
        .size        (size),
        .ld_unsigned (ld_unsigned),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .stall       (stall),
        .align_err   (align_err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .bus_err     (bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wrt, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        mem_rd      = rd;
        mem_wrt     = wrt;
        size        = sz;
        ld_unsigned = uns;
        addr        = a;
        wr_data     = wd;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic run_load_quiet(input logic [31:0] a, input logic [31:0] rdata);
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, a, 32'd0);
        bus_rdata = rdata;
        tick();
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_ack = 1'b0;
        bus_rdata = 32'd0;
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0002, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req: got %b want 0", bus_req); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL rst_bus_we: got %b want 0", bus_we); end
        checks++; if (bus_be !== 4'h0) begin errors++; $display("FAIL rst_bus_be: got %h want 0", bus_be); end
        checks++; if (bus_addr !== 32'd0) begin errors++; $display("FAIL rst_bus_addr: got %h want 0", bus_addr); end
        checks++; if (bus_wdata !== 32'd0) begin errors++; $display("FAIL rst_bus_wdata: got %h want 0", bus_wdata); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL rst_align_err: got %b want 0", align_err); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err: got %b want 0", bus_err); end
        idle_inputs();
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_rel_stall: got %b want 0", stall); end
    endtask

    task automatic test_word_store();
        int n_stall = 0;
        tick();
        drive(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0000_0104, 32'hCAFE_F00D);
        @(negedge clk);
        if (stall) n_stall++;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL ws_idle_req: got %b want 0", bus_req); end
        tick();
        @(negedge clk);
        if (stall) n_stall++;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL ws_req: got %b want 1", bus_req); end
        checks++; if (bus_we !== 1'b1) begin errors++; $display("FAIL ws_we: got %b want 1", bus_we); end
        checks++; if (bus_addr !== 32'h0000_0104) begin errors++; $display("FAIL ws_addr: got %h want 00000104", bus_addr); end
        checks++; if (bus_be !== 4'b1111) begin errors++; $display("FAIL ws_be: got %b want 1111", bus_be); end
        checks++; if (bus_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ws_wdata: got %h want cafef00d", bus_wdata); end
        tick();
        bus_ack = 1'b1;
        @(negedge clk);
        if (stall) n_stall++;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL ws_req_hold: got %b want 1", bus_req); end
        tick();
        bus_ack = 1'b0;
        idle_inputs();
        @(negedge clk);
        if (stall) n_stall++;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL ws_done_req: got %b want 0", bus_req); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL ws_rd_keep: got %h want 0", rd_data); end
        checks++; if (n_stall != 3) begin errors++; $display("FAIL ws_stall_cycles: got %0d want 3", n_stall); end
        tick();
    endtask

    task automatic test_loads();
        logic [1:0]  offs [7] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
        logic [1:0]  szs  [7] = '{SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_WORD, 2'b11};
        logic        unss [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exps [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0034, 32'hFFFF_8012,
                                  32'h0000_3456, 32'h8012_3456, 32'h8012_3456};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, szs[i], unss[i], 32'h0000_0200 | {30'd0, offs[i]}, 32'd0);
            bus_rdata = 32'h8012_3456;
            tick();
            bus_ack = 1'b1;
            @(negedge clk);
            checks++; if (bus_req !== 1'b1 || bus_we !== 1'b0) begin errors++; $display("FAIL ld%0d_req_we: got %b%b want 10", i, bus_req, bus_we); end
            checks++; if (bus_addr !== 32'h0000_0200) begin errors++; $display("FAIL ld%0d_addr: got %h want 00000200", i, bus_addr); end
            tick();
            bus_ack = 1'b0;
            idle_inputs();
            @(negedge clk);
            checks++; if (rd_data !== exps[i]) begin errors++; $display("FAIL ld%0d_data: got %h want %h", i, rd_data, exps[i]); end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld%0d_done_stall: got %b want 0", i, stall); end
            tick();
            @(negedge clk);
            checks++; if (rd_data !== exps[i]) begin errors++; $display("FAIL ld%0d_hold: got %h want %h", i, rd_data, exps[i]); end
            tick();
        end
    endtask

    task automatic test_stores();
        logic [1:0]  szs [5] = '{SZ_HALF, SZ_HALF, SZ_BYTE, SZ_BYTE, SZ_WORD};
        logic [1:0]  offs[5] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd0};
        logic [31:0] wds [5] = '{32'h0000_BEEF, 32'h1234_BEEF, 32'h0000_00A5, 32'hFFFF_FF5A, 32'h0102_0304};
        logic        rds [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0]  bes [5] = '{4'b1100, 4'b0011, 4'b0010, 4'b1000, 4'b1111};
        logic [31:0] ewd [5] = '{32'hBEEF_BEEF, 32'hBEEF_BEEF, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0102_0304};
        for (int i = 0; i < 5; i++) begin
            drive(rds[i], 1'b1, szs[i], 1'b0, 32'h0000_0300 | {30'd0, offs[i]}, wds[i]);
            tick();
            bus_ack = 1'b1;
            @(negedge clk);
            checks++; if (bus_we !== 1'b1) begin errors++; $display("FAIL st%0d_we: got %b want 1", i, bus_we); end
            checks++; if (bus_be !== bes[i]) begin errors++; $display("FAIL st%0d_be: got %b want %b", i, bus_be, bes[i]); end
            checks++; if (bus_wdata !== ewd[i]) begin errors++; $display("FAIL st%0d_wdata: got %h want %h", i, bus_wdata, ewd[i]); end
            checks++; if (bus_addr !== 32'h0000_0300) begin errors++; $display("FAIL st%0d_addr: got %h want 00000300", i, bus_addr); end
            tick();
            bus_ack = 1'b0;
            idle_inputs();
            @(negedge clk);
            checks++; if (rd_data !== 32'h8012_3456) begin errors++; $display("FAIL st%0d_rd_keep: got %h want 80123456", i, rd_data); end
            tick();
        end
    endtask

    task automatic test_misalign();
        logic [1:0]  szs [3] = '{SZ_WORD, SZ_HALF, 2'b11};
        logic [31:0] adrs[3] = '{32'h0000_0506, 32'h0000_0501, 32'h0000_0503};
        logic        wrs [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(~wrs[i], wrs[i], szs[i], 1'b0, adrs[i], 32'h1111_2222);
            @(negedge clk);
            checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL mis%0d_err: got %b want 1", i, align_err); end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis%0d_stall: got %b want 0", i, stall); end
            checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL mis%0d_rd: got %h want 0", i, rd_data); end
            tick();
            idle_inputs();
            @(negedge clk);
            checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL mis%0d_pulse: got %b want 0", i, align_err); end
            checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL mis%0d_req: got %b want 0", i, bus_req); end
            tick();
        end
    endtask

    task automatic test_timeout();
        int n_req = 0;
        run_load_quiet(32'h0000_0400, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++; if (rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_pre_rd: got %h want deadbeef", rd_data); end
        tick();
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0404, 32'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus_req) break;
            n_req++;
            tick();
        end
        checks++; if (n_req != 4) begin errors++; $display("FAIL to_req_cycles: got %0d want 4", n_req); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_bus_err: got %b want 1", bus_err); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL to_rd_zero: got %h want 0", rd_data); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL to_stall: got %b want 0", stall); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse: got %b want 0", bus_err); end
        tick();
    endtask

    task automatic test_reset_mid_req();
        run_load_quiet(32'h0000_0600, 32'h1122_3344);
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0604, 32'd0);
        bus_rdata = 32'h5566_7788;
        tick();
        @(negedge clk);
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rmr_req_before: got %b want 1", bus_req); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rmr_req_async: got %b want 0", bus_req); end
        checks++; if (bus_addr !== 32'd0) begin errors++; $display("FAIL rmr_addr: got %h want 0", bus_addr); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rmr_rd_async: got %h want 0", rd_data); end
        tick();
        reset = 1'b1;
        idle_inputs();
        bus_ack = 1'b1;
        @(negedge clk);
        checks++; if (bus_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rmr_late_ack: got req=%b stall=%b want 0 0", bus_req, stall); end
        tick();
        bus_ack = 1'b0;
        @(negedge clk);
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rmr_rd_after: got %h want 0", rd_data); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rmr_req_after: got %b want 0", bus_req); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_stall = 6'b011011;
        logic [5:0] exp_req   = 6'b010010;
        drive(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0000_0010, 32'hA5A5_0F0F);
        bus_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (stall !== exp_stall[i]) begin errors++; $display("FAIL b2b_stall_c%0d: got %b want %b", i, stall, exp_stall[i]); end
            checks++; if (bus_req !== exp_req[i]) begin errors++; $display("FAIL b2b_req_c%0d: got %b want %b", i, bus_req, exp_req[i]); end
            tick();
        end
        bus_ack = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_loads();
        test_stores();
        test_misalign();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/mips_lsu.md
MIPS_LSU -- requirements
Module: mips_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum bus_ack wait in cycles; 0 disables the timeout.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-low (asserted at 0).
REQ-005 mem_rd  in  1  load request from the datapath.
REQ-006 mem_wrt  in  1  store request from the datapath.
REQ-007 size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as word).
REQ-008 ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend byte/half loads.
REQ-009 addr  in  32  byte address (datapath ALU result).
REQ-010 wr_data  in  32  store data (datapath rt value).
REQ-011 rd_data  out  32  load result to the datapath mem_data input.
REQ-012 stall  out  1  freezes the datapath PC and pipeline while high.
REQ-013 align_err  out  1  one-cycle misalignment pulse.
REQ-014 bus_req, bus_we  out  1 each  bus request and write strobe.
REQ-015 bus_addr  out  32  word address, bits [1:0] = 0.
REQ-016 bus_be  out  4  byte enables, little-endian.
REQ-017 bus_wdata  out  32  lane-steered store data.
REQ-018 bus_ack  in  1  bus completion; bus_rdata  in  32  read data.
REQ-019 bus_err  out  1  one-cycle timeout pulse.

Function
REQ-020 SHALL implement FSM states IDLE, REQ and DONE.
REQ-021 IDLE, aligned access (mem_rd|mem_wrt): SHALL register the bus_* outputs and go to REQ; stall=1 combinationally in this cycle.
REQ-022 REQ: SHALL hold bus_req=1 with all bus_* stable until bus_ack; stall=1.
REQ-023 REQ with bus_ack: SHALL drop bus_req next edge, register the extended load data and go to DONE.
REQ-024 DONE: stall=0 and rd_data valid; SHALL go to IDLE next edge and start no new access in DONE.
REQ-025 Minimum access is 3 cycles (IDLE, REQ with ack, DONE).
REQ-026 Write: bus_be is 1<<addr[1:0] for byte, 0011/1100 by addr[1] for half, 1111 for word.
REQ-027 Write: bus_wdata replicates the byte 4x, the half 2x, or passes the word through.
REQ-028 Read: SHALL select the lane by addr[1:0] and extend per ld_unsigned; word loads are unmodified.
REQ-029 mem_rd and mem_wrt both high SHALL execute as a write.
REQ-030 Misalignment (half with addr[0]=1, word with addr[1:0]!=0): no bus transaction, align_err=1 for that cycle, stall=0, rd_data=0, stay IDLE.
REQ-031 Timeout: a counter clears on entry to REQ; when it reaches TIMEOUT without ack, SHALL drop bus_req, pulse bus_err, force rd_data=0 and go to DONE.
REQ-032 bus_ack outside REQ SHALL be ignored.
REQ-033 rd_data SHALL hold its last value outside DONE; stores leave rd_data unchanged.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rd_data=0, align_err=0, bus_err=0 and clear the timeout counter.
REQ-035 Reset mid-REQ SHALL abandon the transaction; a late bus_ack after release is ignored (REQ-032).
REQ-036 First access after reset release SHALL behave per REQ-021.

Structure
REQ-037 Package mips_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state encoding and the TIMEOUT default.
REQ-038 Lane steering and extension SHALL live in combinational sub-module lsu_lane_align; mips_lsu holds the FSM, counter and registers.

Verification
REQ-039 Word store, addr=0x0000_0104, wr_data=0xCAFE_F00D, ack on 2nd REQ cycle -> bus_addr=0x104, be=1111, wdata=0xCAFEF00D, stall high 3 cycles, then DONE.
REQ-040 Byte load, addr=0x...03, bus_rdata=0x80_12_34_56 -> rd_data=0xFFFF_FF80 signed, 0x0000_0080 with ld_unsigned=1.
REQ-041 Half store, addr=0x...02, wr_data=0x0000_BEEF -> be=1100, wdata=0xBEEF_BEEF.
REQ-042 Word load at addr=0x...06 -> align_err one cycle, bus_req never asserts, stall=0.
REQ-043 TIMEOUT=4 with no ack -> bus_req high exactly 4 cycles, bus_err pulse, rd_data=0, next cycle stall=0.
REQ-044 reset=0 asserted mid-REQ, then ack after release -> bus_req drops asynchronously, FSM stays IDLE, rd_data=0.
